// File: rtl/ee457_id_operand_stage_if.sv
// Decode-stage operand bundle: ID instruction, register file read port, MEM/WB bypass
// sources, and the ID/EX pipeline register outputs.
interface ee457_id_operand_stage_if #(
    parameter int unsigned ADDR_SIZE = 5,
    parameter int unsigned DATA_SIZE = 32
);
    logic                 id_valid;
    logic [ADDR_SIZE-1:0] id_rs;
    logic [ADDR_SIZE-1:0] id_rt;
    logic                 id_use_rs;
    logic                 id_use_rt;
    logic [ADDR_SIZE-1:0] id_dest;
    logic                 id_regwrite;
    logic                 id_memread;
    logic                 flush;

    logic [ADDR_SIZE-1:0] ra;
    logic [ADDR_SIZE-1:0] rb;
    logic [DATA_SIZE-1:0] radata;
    logic [DATA_SIZE-1:0] rbdata;

    logic                 mem_regwrite;
    logic                 mem_memread;
    logic [ADDR_SIZE-1:0] mem_dest;
    logic [DATA_SIZE-1:0] mem_result;

    logic                 wb_wen;
    logic [ADDR_SIZE-1:0] wb_wa;
    logic [DATA_SIZE-1:0] wb_wdata;

    logic                 stall;
    logic                 idex_valid;
    logic                 idex_regwrite;
    logic                 idex_memread;
    logic [ADDR_SIZE-1:0] idex_dest;
    logic [DATA_SIZE-1:0] idex_a;
    logic [DATA_SIZE-1:0] idex_b;
    logic [31:0]          stall_cycles;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest,
               id_regwrite, id_memread, flush,
               radata, rbdata,
               mem_regwrite, mem_memread, mem_dest, mem_result,
               wb_wen, wb_wa, wb_wdata,
        input  ra, rb, stall,
               idex_valid, idex_regwrite, idex_memread, idex_dest,
               idex_a, idex_b, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest,
               id_regwrite, id_memread, flush,
               radata, rbdata,
               mem_regwrite, mem_memread, mem_dest, mem_result,
               wb_wen, wb_wa, wb_wdata,
        output ra, rb, stall,
               idex_valid, idex_regwrite, idex_memread, idex_dest,
               idex_a, idex_b, stall_cycles
    );
endinterface

// File: rtl/ee457_id_operand_stage.sv
// ID-stage operand unit: bypass select in front of a non-forwarding register file,
// RAW stall detection, and the ID/EX pipeline register with a stall-cycle counter.
module ee457_id_operand_stage #(
    parameter int unsigned ADDR_SIZE = 5,
    parameter int unsigned DATA_SIZE = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    ee457_id_operand_stage_if.slave  bus
);
    localparam int unsigned CNT_W = 32;
    localparam logic [ADDR_SIZE-1:0] ZERO_REG = '0;
    localparam logic [CNT_W-1:0]     CNT_MAX  = '1;

    logic                 idex_valid_q;
    logic                 idex_regwrite_q;
    logic                 idex_memread_q;
    logic [ADDR_SIZE-1:0] idex_dest_q;
    logic [DATA_SIZE-1:0] idex_a_q;
    logic [DATA_SIZE-1:0] idex_b_q;
    logic [CNT_W-1:0]     stall_cycles_q;

    logic                 rs_needed;
    logic                 rt_needed;
    logic                 ex_writes;
    logic                 mem_load;
    logic                 mem_alu;
    logic                 ex_hazard;
    logic                 mem_load_hazard;
    logic                 stall_int;
    logic [DATA_SIZE-1:0] op_a;
    logic [DATA_SIZE-1:0] op_b;

    // MEM result beats WB data; r0 is hard zero; an unused source passes RF data untouched.
    function automatic logic [DATA_SIZE-1:0] select_operand(
        input logic [ADDR_SIZE-1:0] src,
        input logic                 use_src,
        input logic [DATA_SIZE-1:0] rf_data,
        input logic                 mem_fwd,
        input logic [ADDR_SIZE-1:0] mem_dest,
        input logic [DATA_SIZE-1:0] mem_result,
        input logic                 wb_wen,
        input logic [ADDR_SIZE-1:0] wb_wa,
        input logic [DATA_SIZE-1:0] wb_wdata
    );
        logic [DATA_SIZE-1:0] sel;
        sel = rf_data;
        if (src == ZERO_REG) begin
            sel = '0;
        end else if (use_src) begin
            if (mem_fwd && (mem_dest == src)) begin
                sel = mem_result;
            end else if (wb_wen && (wb_wa == src)) begin
                sel = wb_wdata;
            end
        end
        return sel;
    endfunction

    // Hazard detection and operand selection.
    always_comb begin
        rs_needed       = 1'b0;
        rt_needed       = 1'b0;
        ex_writes       = 1'b0;
        mem_load        = 1'b0;
        mem_alu         = 1'b0;
        ex_hazard       = 1'b0;
        mem_load_hazard = 1'b0;
        stall_int       = 1'b0;
        op_a            = '0;
        op_b            = '0;

        rs_needed = bus.id_valid && bus.id_use_rs && (bus.id_rs != ZERO_REG);
        rt_needed = bus.id_valid && bus.id_use_rt && (bus.id_rt != ZERO_REG);
        ex_writes = idex_valid_q && idex_regwrite_q;
        mem_load  = bus.mem_regwrite && bus.mem_memread;
        mem_alu   = bus.mem_regwrite && !bus.mem_memread;

        // The EX result is not computed yet; a load in MEM has no data until WB.
        ex_hazard = ex_writes &&
                    ((rs_needed && (bus.id_rs == idex_dest_q)) ||
                     (rt_needed && (bus.id_rt == idex_dest_q)));
        mem_load_hazard = mem_load &&
                          ((rs_needed && (bus.id_rs == bus.mem_dest)) ||
                           (rt_needed && (bus.id_rt == bus.mem_dest)));

        stall_int = (ex_hazard || mem_load_hazard) && !bus.flush;

        op_a = select_operand(bus.id_rs, bus.id_use_rs, bus.radata,
                              mem_alu, bus.mem_dest, bus.mem_result,
                              bus.wb_wen, bus.wb_wa, bus.wb_wdata);
        op_b = select_operand(bus.id_rt, bus.id_use_rt, bus.rbdata,
                              mem_alu, bus.mem_dest, bus.mem_result,
                              bus.wb_wen, bus.wb_wa, bus.wb_wdata);
    end

    // ID/EX pipeline register; a flush or stall turns the slot into a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            idex_valid_q    <= 1'b0;
            idex_regwrite_q <= 1'b0;
            idex_memread_q  <= 1'b0;
            idex_dest_q     <= '0;
            idex_a_q        <= '0;
            idex_b_q        <= '0;
        end else if (bus.flush || stall_int) begin
            idex_valid_q    <= 1'b0;
            idex_regwrite_q <= 1'b0;
            idex_memread_q  <= 1'b0;
            idex_dest_q     <= '0;
            idex_a_q        <= '0;
            idex_b_q        <= '0;
        end else begin
            idex_valid_q    <= bus.id_valid;
            idex_regwrite_q <= bus.id_regwrite && bus.id_valid;
            idex_memread_q  <= bus.id_memread && bus.id_valid;
            idex_dest_q     <= bus.id_dest;
            idex_a_q        <= op_a;
            idex_b_q        <= op_b;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else if (stall_int && (stall_cycles_q != CNT_MAX)) begin
            stall_cycles_q <= stall_cycles_q + CNT_W'(1);
        end
    end

    assign bus.ra            = bus.id_rs;
    assign bus.rb            = bus.id_rt;
    assign bus.stall         = stall_int;
    assign bus.idex_valid    = idex_valid_q;
    assign bus.idex_regwrite = idex_regwrite_q;
    assign bus.idex_memread  = idex_memread_q;
    assign bus.idex_dest     = idex_dest_q;
    assign bus.idex_a        = idex_a_q;
    assign bus.idex_b        = idex_b_q;
    assign bus.stall_cycles  = stall_cycles_q;

endmodule

// File: tb/tb_ee457_id_operand_stage.sv
// Scoreboard bench for ee457_id_operand_stage: directed hazard scenarios followed by
// random traffic, checked against an instruction-level reference model.
module tb_ee457_id_operand_stage;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ee457_id_operand_stage_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus ();
    ee457_id_operand_stage #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic          rst;
        logic          id_valid;
        logic [AW-1:0] id_rs, id_rt, id_dest;
        logic          use_rs, use_rt, regwrite, memread, flush;
        logic [DW-1:0] radata, rbdata;
        logic          mem_regwrite, mem_memread;
        logic [AW-1:0] mem_dest;
        logic [DW-1:0] mem_result;
        logic          wb_wen;
        logic [AW-1:0] wb_wa;
        logic [DW-1:0] wb_wdata;
    } stim_t;

    // The instruction sitting in EX, as the model sees it.
    typedef struct {
        logic          valid, regwrite, memread;
        logic [AW-1:0] dest;
        logic [DW-1:0] a, b;
    } ex_t;

    typedef struct { int due; ex_t ex; logic [31:0] cnt; } exp_ex_t;
    typedef struct { int due; logic stall; logic [AW-1:0] ra, rb; } exp_st_t;

    ex_t         m_ex;
    logic [31:0] m_cnt;
    int          cyc = 0;
    int          vectors = 0;
    int          checks = 0;
    int          miscompares = 0;
    bit          primed = 0;
    exp_ex_t     eq[$];
    exp_st_t     sq[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    // Value of register r cannot be obtained this cycle: EX will write it, or a load in MEM will.
    function automatic bit unavailable(input ex_t ex, input stim_t s, input logic [AW-1:0] r);
        bit ex_pending, mem_pending;
        ex_pending  = ex.valid && ex.regwrite && (ex.dest == r);
        mem_pending = s.mem_regwrite && s.mem_memread && (s.mem_dest == r);
        return ex_pending || mem_pending;
    endfunction

    function automatic logic [DW-1:0] value_of(input stim_t s, input logic [AW-1:0] r,
                                               input logic used, input logic [DW-1:0] rf);
        if (r == 0)                                                  return '0;
        if (!used)                                                   return rf;
        if (s.mem_regwrite && !s.mem_memread && s.mem_dest == r)     return s.mem_result;
        if (s.wb_wen && s.wb_wa == r)                                return s.wb_wdata;
        return rf;
    endfunction

    task automatic apply(input stim_t s);
        bit      need_rs, need_rt, exp_stall;
        exp_st_t st;
        exp_ex_t nx;
        @(posedge clk);
        #1;
        rst              = s.rst;
        bus.id_valid     = s.id_valid;
        bus.id_rs        = s.id_rs;
        bus.id_rt        = s.id_rt;
        bus.id_use_rs    = s.use_rs;
        bus.id_use_rt    = s.use_rt;
        bus.id_dest      = s.id_dest;
        bus.id_regwrite  = s.regwrite;
        bus.id_memread   = s.memread;
        bus.flush        = s.flush;
        bus.radata       = s.radata;
        bus.rbdata       = s.rbdata;
        bus.mem_regwrite = s.mem_regwrite;
        bus.mem_memread  = s.mem_memread;
        bus.mem_dest     = s.mem_dest;
        bus.mem_result   = s.mem_result;
        bus.wb_wen       = s.wb_wen;
        bus.wb_wa        = s.wb_wa;
        bus.wb_wdata     = s.wb_wdata;
        cyc++;
        vectors++;

        need_rs   = s.id_valid && s.use_rs && (s.id_rs != 0);
        need_rt   = s.id_valid && s.use_rt && (s.id_rt != 0);
        exp_stall = ((need_rs && unavailable(m_ex, s, s.id_rs)) ||
                     (need_rt && unavailable(m_ex, s, s.id_rt))) && !s.flush;
        if (primed) begin
            st = '{due: cyc, stall: exp_stall, ra: s.id_rs, rb: s.id_rt};
            sq.push_back(st);
        end

        if (s.rst) begin
            m_ex  = '{default: '0};
            m_cnt = 0;
        end else begin
            if (exp_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (s.flush || exp_stall) begin
                m_ex = '{default: '0};
            end else begin
                m_ex.valid    = s.id_valid;
                m_ex.regwrite = s.id_valid && s.regwrite;
                m_ex.memread  = s.id_valid && s.memread;
                m_ex.dest     = s.id_dest;
                m_ex.a        = value_of(s, s.id_rs, s.use_rs, s.radata);
                m_ex.b        = value_of(s, s.id_rt, s.use_rt, s.rbdata);
            end
        end
        nx = '{due: cyc + 1, ex: m_ex, cnt: m_cnt};
        eq.push_back(nx);
    endtask

    // Monitor: compares combinational outputs of the current cycle and ID/EX of the previous one.
    always @(negedge clk) begin
        exp_st_t st;
        exp_ex_t e;
        while (sq.size() > 0 && sq[0].due <= cyc) begin
            st = sq.pop_front();
            chk("stall", DW'(bus.stall), DW'(st.stall));
            chk("ra", DW'(bus.ra), DW'(st.ra));
            chk("rb", DW'(bus.rb), DW'(st.rb));
        end
        while (eq.size() > 0 && eq[0].due <= cyc) begin
            e = eq.pop_front();
            chk("idex_valid", DW'(bus.idex_valid), DW'(e.ex.valid));
            chk("idex_regwrite", DW'(bus.idex_regwrite), DW'(e.ex.regwrite));
            chk("idex_memread", DW'(bus.idex_memread), DW'(e.ex.memread));
            chk("idex_dest", DW'(bus.idex_dest), DW'(e.ex.dest));
            chk("idex_a", bus.idex_a, e.ex.a);
            chk("idex_b", bus.idex_b, e.ex.b);
            chk("stall_cycles", bus.stall_cycles, e.cnt);
        end
    end

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    initial begin
        stim_t s;
        m_ex  = '{default: '0};
        m_cnt = 0;

        s = idle(); s.rst = 1'b1;
        apply(s);
        primed = 1;
        apply(s);

        // WB bypass on rt, plain register file on rs
        s = idle(); s.id_valid = 1; s.id_rs = 3; s.id_rt = 4; s.use_rs = 1; s.use_rt = 1;
        s.radata = 32'h11; s.rbdata = 32'h22; s.wb_wen = 1; s.wb_wa = 4; s.wb_wdata = 32'hAB;
        apply(s); at_neg(); chk("wb_bypass_stall", DW'(bus.stall), 0);
        apply(idle()); at_neg();
        chk("wb_bypass_a", bus.idex_a, 32'h11);
        chk("wb_bypass_b", bus.idex_b, 32'hAB);

        // ALU producer then dependent: one bubble, then MEM forward
        s = idle(); s.id_valid = 1; s.id_dest = 5; s.regwrite = 1;
        apply(s);
        s = idle(); s.id_valid = 1; s.id_rs = 5; s.use_rs = 1; s.radata = 32'h999;
        apply(s); at_neg(); chk("alu_raw_stall1", DW'(bus.stall), 1);
        s.mem_regwrite = 1; s.mem_dest = 5; s.mem_result = 32'h1234;
        apply(s); at_neg();
        chk("alu_raw_stall2", DW'(bus.stall), 0);
        chk("alu_raw_bubble", DW'(bus.idex_valid), 0);
        apply(idle()); at_neg();
        chk("alu_raw_fwd", bus.idex_a, 32'h1234);
        chk("alu_raw_count", bus.stall_cycles, 1);

        // Load producer then dependent: two bubbles, then WB forward
        s = idle(); s.id_valid = 1; s.id_dest = 7; s.regwrite = 1; s.memread = 1;
        apply(s);
        s = idle(); s.id_valid = 1; s.id_rt = 7; s.use_rt = 1; s.rbdata = 32'h777;
        apply(s); at_neg(); chk("load_use_stall1", DW'(bus.stall), 1);
        s.mem_regwrite = 1; s.mem_memread = 1; s.mem_dest = 7;
        apply(s); at_neg(); chk("load_use_stall2", DW'(bus.stall), 1);
        s.mem_regwrite = 0; s.mem_memread = 0; s.mem_dest = 0;
        s.wb_wen = 1; s.wb_wa = 7; s.wb_wdata = 32'hDEAD;
        apply(s); at_neg(); chk("load_use_stall3", DW'(bus.stall), 0);
        apply(idle()); at_neg();
        chk("load_use_fwd", bus.idex_b, 32'hDEAD);
        chk("load_use_count", bus.stall_cycles, 3);

        // r0 is never a hazard and always reads as zero
        s = idle(); s.id_valid = 1; s.id_dest = 0; s.regwrite = 1;
        apply(s);
        s = idle(); s.id_valid = 1; s.id_rs = 0; s.use_rs = 1; s.radata = 32'h55;
        apply(s); at_neg(); chk("r0_stall", DW'(bus.stall), 0);
        apply(idle()); at_neg(); chk("r0_value", bus.idex_a, 0);

        // Flush overrides a hazard
        s = idle(); s.id_valid = 1; s.id_dest = 5; s.regwrite = 1;
        apply(s);
        s = idle(); s.id_valid = 1; s.id_rs = 5; s.use_rs = 1; s.flush = 1;
        apply(s); at_neg(); chk("flush_stall", DW'(bus.stall), 0);
        apply(idle()); at_neg();
        chk("flush_valid", DW'(bus.idex_valid), 0);
        chk("flush_count", bus.stall_cycles, 3);

        // Reset in the middle of a load-use stall
        s = idle(); s.id_valid = 1; s.id_dest = 7; s.regwrite = 1; s.memread = 1;
        apply(s);
        s = idle(); s.id_valid = 1; s.id_rt = 7; s.use_rt = 1;
        apply(s); at_neg(); chk("rst_mid_stall1", DW'(bus.stall), 1);
        s.rst = 1; s.mem_regwrite = 1; s.mem_memread = 1; s.mem_dest = 7;
        apply(s); at_neg(); chk("rst_mid_stall2", DW'(bus.stall), 1);
        apply(idle()); at_neg();
        chk("rst_valid", DW'(bus.idex_valid), 0);
        chk("rst_dest", DW'(bus.idex_dest), 0);
        chk("rst_b", bus.idex_b, 0);
        chk("rst_count", bus.stall_cycles, 0);

        // Random traffic over a small register window to provoke collisions
        for (int i = 0; i < 3000; i++) begin
            s.rst          = ($urandom_range(0, 299) == 0);
            s.id_valid     = ($urandom_range(0, 7) != 0);
            s.id_rs        = AW'($urandom_range(0, 7));
            s.id_rt        = AW'($urandom_range(0, 7));
            s.use_rs       = 1'($urandom);
            s.use_rt       = 1'($urandom);
            s.id_dest      = AW'($urandom_range(0, 7));
            s.regwrite     = 1'($urandom);
            s.memread      = 1'($urandom);
            s.flush        = ($urandom_range(0, 7) == 0);
            s.radata       = $urandom;
            s.rbdata       = $urandom;
            s.mem_regwrite = 1'($urandom);
            s.mem_memread  = 1'($urandom);
            s.mem_dest     = AW'($urandom_range(0, 7));
            s.mem_result   = $urandom;
            s.wb_wen       = 1'($urandom);
            s.wb_wa        = AW'($urandom_range(0, 7));
            s.wb_wdata     = $urandom;
            apply(s);
        end
        apply(idle());

        // Let the monitor retire the last ID/EX expectation
        @(posedge clk);
        #1;
        cyc++;
        at_neg();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
